// File: rtl/param_control_unit.sv
// param_control_unit: multi-cycle FETCH/DECODE/EXEC/HALT instruction control unit.
// Decodes {opcode, operand} words into one-cycle PC/register/memory pulses and
// conditional branches on latched zero/carry flags.
// Optional return-address stack: define CALL_STACK_EN to enable CALL/RET.
module param_control_unit #(
    parameter int unsigned INSTR_WIDTH  = 8,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned PC_WIDTH     = 4,
    parameter int unsigned STACK_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   zero_flag,
    input  logic                   carry_flag,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic                   fetch_req,
    output logic                   pc_enable,
    output logic                   pc_load,
    output logic [PC_WIDTH-1:0]    jump_target,
    output logic                   reg_write_enable,
    output logic                   mem_write_enable,
    output logic [2:0]             alu_op,
    output logic                   halt,
    output logic                   stack_err
);

    localparam int unsigned OPND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

    if (OPCODE_WIDTH < 4 || OPCODE_WIDTH >= INSTR_WIDTH || STACK_DEPTH < 1) begin : g_bad_cfg
        $error("param_control_unit: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_JUMP  = 4'h6,
        OP_HALT  = 4'h7,
        OP_JZ    = 4'h8,
        OP_JNZ   = 4'h9,
        OP_JC    = 4'hA,
        OP_JNC   = 4'hB,
        OP_CALL  = 4'hC,
        OP_RET   = 4'hD,
        OP_XOR   = 4'hE,
        OP_NOP   = 4'hF
    } opcode_e;

    // Any set bit above the 4-bit opcode map turns the word into a NOP.
    function automatic opcode_e op_class(input logic [OPCODE_WIDTH-1:0] opc);
        if ((opc >> 4) != '0) return OP_NOP;
        return opcode_e'(opc[3:0]);
    endfunction

    function automatic logic [2:0] alu_sel(input opcode_e op);
        case (op)
            OP_LOAD: return 3'b101;
            OP_ADD:  return 3'b000;
            OP_SUB:  return 3'b001;
            OP_AND:  return 3'b010;
            OP_OR:   return 3'b011;
            OP_XOR:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    state_t                  state;
    logic [INSTR_WIDTH-1:0]  ir;
    logic                    z_q;
    logic                    c_q;
    logic                    flags_upd;

    logic [OPCODE_WIDTH-1:0] ir_opc;
    logic [OPCODE_WIDTH-1:0] in_opc;
    logic [OPND_WIDTH-1:0]   ir_opnd;
    logic [PC_WIDTH-1:0]     opnd_tgt;

    logic                    dec_pe;
    logic                    dec_pl;
    logic                    dec_rw;
    logic                    dec_mw;
    logic                    dec_halt;
    logic                    dec_flags;
    logic [PC_WIDTH-1:0]     dec_tgt;

    assign ir_opc   = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign ir_opnd  = ir[OPND_WIDTH-1:0];
    assign in_opc   = instruction[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    // Zero-extends or truncates the operand to the PC width.
    assign opnd_tgt = PC_WIDTH'(ir_opnd);

`ifdef CALL_STACK_EN
    localparam int unsigned SP_WIDTH  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0]  stack_mem [STACK_DEPTH];
    logic [SP_WIDTH-1:0]  sp;
    logic                 stack_full;
    logic                 stack_empty;
    logic [IDX_WIDTH-1:0] push_idx;
    logic [IDX_WIDTH-1:0] top_idx;
    logic                 dec_push;
    logic                 dec_pop;
    logic                 dec_stack_err;
    logic                 stack_err_q;

    assign stack_full  = (sp == SP_WIDTH'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = IDX_WIDTH'(sp);
    assign top_idx     = IDX_WIDTH'(sp - SP_WIDTH'(1));
    assign stack_err   = stack_err_q;

    // Return-address storage; contents survive reset, only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (state == S_DECODE && dec_push) begin
            stack_mem[push_idx] <= pc_in + PC_WIDTH'(1);
        end
    end
`else
    assign stack_err = 1'b0;
`endif

    // Decode the latched instruction into the pulse set to be driven during EXEC.
    always_comb begin
        dec_pe    = 1'b0;
        dec_pl    = 1'b0;
        dec_rw    = 1'b0;
        dec_mw    = 1'b0;
        dec_halt  = 1'b0;
        dec_flags = 1'b0;
        dec_tgt   = opnd_tgt;
`ifdef CALL_STACK_EN
        dec_push      = 1'b0;
        dec_pop       = 1'b0;
        dec_stack_err = 1'b0;
`endif
        case (op_class(ir_opc))
            OP_LOAD: begin
                dec_rw = 1'b1;
                dec_pe = 1'b1;
            end
            OP_STORE: begin
                dec_mw = 1'b1;
                dec_pe = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec_rw    = 1'b1;
                dec_pe    = 1'b1;
                dec_flags = 1'b1;
            end
            OP_JUMP: dec_pl = 1'b1;
            OP_HALT: dec_halt = 1'b1;
            OP_JZ:   if (z_q)  dec_pl = 1'b1; else dec_pe = 1'b1;
            OP_JNZ:  if (!z_q) dec_pl = 1'b1; else dec_pe = 1'b1;
            OP_JC:   if (c_q)  dec_pl = 1'b1; else dec_pe = 1'b1;
            OP_JNC:  if (!c_q) dec_pl = 1'b1; else dec_pe = 1'b1;
`ifdef CALL_STACK_EN
            OP_CALL: begin
                if (stack_full) begin
                    dec_halt      = 1'b1;
                    dec_stack_err = 1'b1;
                end else begin
                    dec_push = 1'b1;
                    dec_pl   = 1'b1;
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    dec_halt      = 1'b1;
                    dec_stack_err = 1'b1;
                end else begin
                    dec_pop = 1'b1;
                    dec_pl  = 1'b1;
                    dec_tgt = stack_mem[top_idx];
                end
            end
`endif
            // NOP, unused upper-opcode words, and CALL/RET when no stack is built.
            default: dec_pe = 1'b1;
        endcase
    end

    // Sequencer: fetch handshake, registered EXEC pulses, flag latch and sticky halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_FETCH;
            fetch_req        <= 1'b1;
            ir               <= '0;
            alu_op           <= 3'b000;
            pc_enable        <= 1'b0;
            pc_load          <= 1'b0;
            jump_target      <= '0;
            reg_write_enable <= 1'b0;
            mem_write_enable <= 1'b0;
            halt             <= 1'b0;
            z_q              <= 1'b0;
            c_q              <= 1'b0;
            flags_upd        <= 1'b0;
`ifdef CALL_STACK_EN
            sp               <= '0;
            stack_err_q      <= 1'b0;
`endif
        end else begin
            pc_enable        <= 1'b0;
            pc_load          <= 1'b0;
            reg_write_enable <= 1'b0;
            mem_write_enable <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir        <= instruction;
                        // alu_op is set at fetch so it is stable through DECODE and EXEC.
                        alu_op    <= alu_sel(op_class(in_opc));
                        fetch_req <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_halt) begin
                        halt  <= 1'b1;
                        state <= S_HALT;
`ifdef CALL_STACK_EN
                        if (dec_stack_err) stack_err_q <= 1'b1;
`endif
                    end else begin
                        pc_enable        <= dec_pe;
                        pc_load          <= dec_pl;
                        reg_write_enable <= dec_rw;
                        mem_write_enable <= dec_mw;
                        flags_upd        <= dec_flags;
                        if (dec_pl) jump_target <= dec_tgt;
                        state <= S_EXEC;
`ifdef CALL_STACK_EN
                        if (dec_push) sp <= sp + SP_WIDTH'(1);
                        if (dec_pop)  sp <= sp - SP_WIDTH'(1);
`endif
                    end
                end
                S_EXEC: begin
                    if (flags_upd) begin
                        z_q <= zero_flag;
                        c_q <= carry_flag;
                    end
                    fetch_req <= 1'b1;
                    state     <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
